// File: rtl/toy_bus_dtcm_tgt_node.sv
// DTCM target endpoint: ToyBus request -> 1-cycle-latency SRAM access -> in-order ack FIFO.
// Optional out-of-range address check enabled by defining TOY_BUS_DTCM_ADDR_CHK_EN (adds ack_err).
module toy_bus_dtcm_tgt_node #(
  parameter int ADDR_W    = 12,
  parameter int ACK_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_strb,
  input  logic [255:0]      req_data,
  input  logic              req_opcode,
  input  logic [3:0]        req_src_id,
  input  logic [3:0]        req_tgt_id,
  input  logic [9:0]        req_sideband,
  output logic              ack_vld,
  input  logic              ack_rdy,
  output logic              ack_opcode,
  output logic [255:0]      ack_data,
  output logic [9:0]        ack_sideband,
  output logic [3:0]        ack_src_id,
  output logic [3:0]        ack_tgt_id,
`ifdef TOY_BUS_DTCM_ADDR_CHK_EN
  output logic              ack_err,
`endif
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wmask,
  output logic [255:0]      mem_wdata,
  input  logic [255:0]      mem_rdata
);

  localparam int PW = (ACK_DEPTH > 1) ? $clog2(ACK_DEPTH) : 1;
  localparam int CW = $clog2(ACK_DEPTH + 1);

  typedef struct packed {
    logic         opcode;
    logic [255:0] data;
    logic [9:0]   sideband;
    logic [3:0]   src_id;
    logic [3:0]   tgt_id;
    logic         err;
  } ack_ent_t;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(ACK_DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  logic              s1_vld_q, s1_op_q, s1_err_q;
  logic [9:0]        s1_sb_q;
  logic [3:0]        s1_src_q, s1_tgt_q;
  ack_ent_t          fifo_q [ACK_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [CW:0]       occ_s;
  logic              fire_s, in_rng_s, push_s, pop_s;
  ack_ent_t          push_ent_s, head_s;
  logic              unused_s;

  assign unused_s = ^{req_addr[4:0], req_addr[31:ADDR_W+5]};

  // Request acceptance and combinational SRAM drive (held at zero in reset)
  always_comb begin
    occ_s    = {1'b0, fifo_cnt_q} + {{CW{1'b0}}, s1_vld_q};
    req_rdy  = (occ_s < (CW+1)'(ACK_DEPTH));
    fire_s   = req_vld & req_rdy;
`ifdef TOY_BUS_DTCM_ADDR_CHK_EN
    in_rng_s = ~|req_addr[31:ADDR_W+5];
`else
    in_rng_s = 1'b1;
`endif
    mem_en    = rst_n & fire_s & in_rng_s & (~req_opcode | (|req_strb));
    mem_wen   = rst_n & fire_s & in_rng_s & req_opcode;
    mem_addr  = rst_n ? req_addr[ADDR_W+4:5] : {ADDR_W{1'b0}};
    mem_wmask = rst_n ? req_strb : 32'h0;
    mem_wdata = rst_n ? req_data : 256'h0;
  end

  // Stage s1: request attributes waiting for the SRAM read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_op_q  <= 1'b0;
      s1_err_q <= 1'b0;
      s1_sb_q  <= 10'h0;
      s1_src_q <= 4'h0;
      s1_tgt_q <= 4'h0;
    end else begin
      s1_vld_q <= fire_s;
      if (fire_s) begin
        s1_op_q  <= req_opcode;
        s1_err_q <= ~in_rng_s;
        s1_sb_q  <= req_sideband;
        s1_src_q <= req_src_id;
        s1_tgt_q <= req_tgt_id;
      end else begin
        s1_op_q  <= s1_op_q;
        s1_err_q <= s1_err_q;
        s1_sb_q  <= s1_sb_q;
        s1_src_q <= s1_src_q;
        s1_tgt_q <= s1_tgt_q;
      end
    end
  end

  // Ack entry assembly, FIFO handshakes and head-entry output decode
  always_comb begin
    push_s              = s1_vld_q;
    pop_s               = ack_vld & ack_rdy;
    push_ent_s.opcode   = s1_op_q;
    push_ent_s.sideband = s1_sb_q;
    push_ent_s.src_id   = s1_tgt_q;
    push_ent_s.tgt_id   = s1_src_q;
    push_ent_s.err      = s1_err_q;
    if (s1_err_q) begin
      push_ent_s.data = {256{1'b1}};
    end else if (s1_op_q) begin
      push_ent_s.data = 256'h0;
    end else begin
      push_ent_s.data = mem_rdata;
    end
    case ({push_s, pop_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    head_s       = fifo_q[rd_ptr_q];
    ack_vld      = (fifo_cnt_q != {CW{1'b0}});
    ack_opcode   = head_s.opcode;
    ack_data     = head_s.data;
    ack_sideband = head_s.sideband;
    ack_src_id   = head_s.src_id;
    ack_tgt_id   = head_s.tgt_id;
`ifdef TOY_BUS_DTCM_ADDR_CHK_EN
    ack_err      = head_s.err;
`endif
  end

  // Circular ack FIFO; s1 never finds it full because req_rdy counts s1 as occupied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ACK_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      fifo_cnt_q <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        fifo_q[wr_ptr_q] <= push_ent_s;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_q         <= wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_q <= rd_ptr_q;
      end
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

endmodule

// File: tb/tb_toy_bus_dtcm_tgt_node.sv
// Scoreboard bench for toy_bus_dtcm_tgt_node: directed cases plus randomized traffic vs a byte-level memory model.
module tb_toy_bus_dtcm_tgt_node;
  localparam int ADDR_W    = 12;
  localparam int ACK_DEPTH = 3;
  localparam int WORDS     = 1 << ADDR_W;

  logic clk, rst_n, req_vld, req_rdy, req_opcode, ack_vld, ack_rdy, ack_opcode;
  logic [31:0] req_addr, req_strb, mem_wmask;
  logic [255:0] req_data, ack_data, mem_wdata, mem_rdata;
  logic [3:0] req_src_id, req_tgt_id, ack_src_id, ack_tgt_id;
  logic [9:0] req_sideband, ack_sideband;
  logic mem_en, mem_wen;
  logic [ADDR_W-1:0] mem_addr;
`ifdef TOY_BUS_DTCM_ADDR_CHK_EN
  logic ack_err;
`endif

  toy_bus_dtcm_tgt_node #(.ADDR_W(ADDR_W), .ACK_DEPTH(ACK_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr), .req_strb(req_strb),
    .req_data(req_data), .req_opcode(req_opcode), .req_src_id(req_src_id),
    .req_tgt_id(req_tgt_id), .req_sideband(req_sideband),
    .ack_vld(ack_vld), .ack_rdy(ack_rdy), .ack_opcode(ack_opcode), .ack_data(ack_data),
    .ack_sideband(ack_sideband), .ack_src_id(ack_src_id), .ack_tgt_id(ack_tgt_id),
`ifdef TOY_BUS_DTCM_ADDR_CHK_EN
    .ack_err(ack_err),
`endif
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] merge(input logic [255:0] old, input logic [255:0] wd,
                                         input logic [31:0] strb);
    logic [255:0] r;
    r = old;
    for (int b = 0; b < 32; b++) if (strb[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // SRAM macro: write applied at the edge, read data registered one cycle later
  logic [255:0] sram [WORDS];
  initial for (int i = 0; i < WORDS; i++) sram[i] = 256'h0;
  always @(posedge clk) begin
    if (mem_en && mem_wen) sram[mem_addr] <= merge(sram[mem_addr], mem_wdata, mem_wmask);
    if (mem_en && !mem_wen) mem_rdata <= sram[mem_addr];
  end

  // Reference memory, updated in request order from the request stream only
  logic [255:0] ref_mem [WORDS];
  initial for (int i = 0; i < WORDS; i++) ref_mem[i] = 256'h0;

  typedef struct {
    logic op; logic [255:0] data; logic [9:0] sb; logic [3:0] src; logic [3:0] tgt;
    logic err; int fc;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad = 0;
  bit lat_chk = 1'b0;

  task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit addr_err(input logic [31:0] a);
`ifdef TOY_BUS_DTCM_ADDR_CHK_EN
    return (a >> (ADDR_W + 5)) != 32'h0;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: pops the scoreboard on every ack handshake and checks hold-while-stalled
  logic [275:0] prev_ack;
  bit stall_prev = 1'b0;
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) chk("ack_hold", {ack_vld, ack_opcode, ack_data, ack_sideband, ack_src_id, ack_tgt_id}, prev_ack);
      stall_prev = ack_vld && !ack_rdy;
      prev_ack = {ack_vld, ack_opcode, ack_data, ack_sideband, ack_src_id, ack_tgt_id};
      if (ack_vld && ack_rdy) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack actual=ack_vld=1 required=no ack (t=%0t)", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ack_fields", {ack_opcode, ack_data, ack_sideband, ack_src_id, ack_tgt_id},
              {e.op, e.data, e.sb, e.src, e.tgt});
`ifdef TOY_BUS_DTCM_ADDR_CHK_EN
          chk("ack_err", ack_err, e.err);
`endif
          if (lat_chk) chk("ack_latency", cyc - e.fc, 2);
        end
      end
    end
  end

  // One request cycle: drive, check the SRAM side if accepted, record the expected ack
  task automatic drive_cycle(input logic op, input logic [31:0] addr, input logic [31:0] strb,
                             input logic [255:0] data, input logic [9:0] sb,
                             input logic [3:0] src, input logic [3:0] tgt, output bit fired);
    exp_t e;
    int idx;
    bit err, exp_en;
    req_vld = 1'b1; req_opcode = op; req_addr = addr; req_strb = strb;
    req_data = data; req_sideband = sb; req_src_id = src; req_tgt_id = tgt;
    #1;
    fired = req_rdy;
    if (fired) begin
      idx = int'((addr >> 5) % WORDS);
      err = addr_err(addr);
      exp_en = !err && (!op || strb != 32'h0);
      chk("mem_en", mem_en, exp_en);
      if (exp_en) begin
        chk("mem_addr", mem_addr, idx);
        chk("mem_wen", mem_wen, op);
        if (op) chk("mem_wmask", mem_wmask, strb);
      end
      if (op && !err) ref_mem[idx] = merge(ref_mem[idx], data, strb);
      e.op = op; e.sb = sb; e.src = tgt; e.tgt = src; e.err = err; e.fc = cyc;
      e.data = err ? {256{1'b1}} : (op ? 256'h0 : ref_mem[idx]);
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic op, input logic [31:0] addr, input logic [31:0] strb,
                      input logic [255:0] data, input logic [9:0] sb,
                      input logic [3:0] src, input logic [3:0] tgt);
    bit f = 1'b0;
    for (int t = 0; t < 50 && !f; t++) begin
      if (t == 8) ack_rdy = 1'b1;
      drive_cycle(op, addr, strb, data, sb, src, tgt, f);
    end
    if (!f) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    req_vld = 1'b0;
    ack_rdy = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    bit f;
    int acc;
    logic [31:0] a, s;
    rst_n = 1'b0; ack_rdy = 1'b1;
    req_vld = 1'b1; req_opcode = 1'b1; req_addr = 32'h40; req_strb = 32'hFFFFFFFF;
    req_data = {32{8'h5A}}; req_src_id = 4'h0; req_tgt_id = 4'h0; req_sideband = 10'h0;
    repeat (2) @(negedge clk);
    chk("rst_ack_vld", ack_vld, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst_n = 1'b1; req_vld = 1'b0;
    #1;
    chk("post_rst_req_rdy", req_rdy, 1);
    chk("post_rst_ack_vld", ack_vld, 0);
    @(negedge clk);

    send(1'b1, 32'h40, 32'hFFFFFFFF, {32{8'hA5}}, 10'h155, 4'h1, 4'h2);
    send(1'b0, 32'h40, 32'h0, 256'h0, 10'h2AA, 4'h3, 4'h7);
    drain();
    chk("full_write_model", ref_mem[2], {32{8'hA5}});

    send(1'b1, 32'h40, 32'h0000000F, {32{8'h11}}, 10'h001, 4'h1, 4'h2);
    send(1'b0, 32'h40, 32'h0, 256'h0, 10'h002, 4'h1, 4'h2);
    drain();
    chk("partial_write_model", ref_mem[2], {{28{8'hA5}}, {4{8'h11}}});

    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 32'(i * 32), 32'h0, 256'h0, 10'(i), 4'h4, 4'h5, f);
      chk("b2b_req_rdy", f, 1);
    end
    drain();
    lat_chk = 1'b0;

    ack_rdy = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 32'h40, 32'h0, 256'h0, 10'(16 + i), 4'h6, 4'h9, f);
      if (f) acc++;
    end
    chk("stall_accepted", acc, ACK_DEPTH);
    chk("stall_req_rdy", req_rdy, 0);
    drain();
    chk("release_req_rdy", req_rdy, 1);

    send(1'b1, 32'h60, 32'h0, {32{8'hEE}}, 10'h3C3, 4'h2, 4'h8);
    drain();
    chk("zero_strb_no_write", ref_mem[3], 256'h0);

    ack_rdy = 1'b0;
    send(1'b0, 32'h40, 32'h0, 256'h0, 10'h10, 4'h1, 4'h1);
    send(1'b0, 32'h60, 32'h0, 256'h0, 10'h11, 4'h1, 4'h1);
    req_vld = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ack_vld", ack_vld, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1; ack_rdy = 1'b1;
    #1;
    chk("midrst_req_rdy", req_rdy, 1);
    repeat (4) @(negedge clk);
    chk("midrst_no_stale", ack_vld, 0);

`ifdef TOY_BUS_DTCM_ADDR_CHK_EN
    send(1'b0, 32'h80000000, 32'h0, 256'h0, 10'h0AB, 4'h2, 4'h3);
    drain();
`endif

    for (int i = 0; i < 300; i++) begin
      ack_rdy = ($urandom_range(0, 9) < 7);
      a = (($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFE0000) : 32'h0)
          | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
      s = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      send(1'($urandom_range(0, 1)), a, s, {8{$urandom}}, 10'($urandom), 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        req_vld = 1'b0;
        @(negedge clk);
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
